// File: rtl/axi_rr_flag_arbiter.sv
// N-way round-robin arbiter with AXI stall lock and handshake-driven priority pointer.
// Optional macro AXI_RR_QUOTA_EN keeps a winner on top priority for up to QUOTA handshakes.
module axi_rr_flag_arbiter #(
  parameter int N_REQ = 8,
  parameter int WIDTH = (N_REQ > 2) ? $clog2(N_REQ) : 1,
  parameter int QUOTA = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             data_gnt_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] sel_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic [WIDTH-1:0] idx_o,
  output logic [WIDTH-1:0] RR_FLAG_o,
  output logic             lock_o
);

  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [WIDTH-1:0] lidx_q, lidx_d;
  logic [WIDTH-1:0] rr_idx;
  logic [WIDTH-1:0] win_idx;
  logic             lock_hold;
  logic             hs;
  logic             found;
  int               j;

  function automatic logic [WIDTH-1:0] next_idx(input logic [WIDTH-1:0] w);
    if (w == WIDTH'(N_REQ - 1)) return '0;
    return w + WIDTH'(1);
  endfunction

  // Rotating scan starting at the pointer, wrapping at N_REQ-1 (not at 2**WIDTH-1)
  always_comb begin
    rr_idx = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_i[WIDTH'(j)]) begin
        found  = 1'b1;
        rr_idx = WIDTH'(j);
      end
    end
  end

  // A locked requester that drops its request releases the lock immediately
  assign lock_hold = lock_q & req_i[lidx_q];
  assign win_idx   = lock_hold ? lidx_q : rr_idx;
  assign valid_o   = |req_i;
  assign hs        = valid_o & data_gnt_i;
  assign idx_o     = win_idx;
  assign RR_FLAG_o = ptr_q;
  assign lock_o    = lock_q;
  assign gnt_o     = sel_o & {N_REQ{data_gnt_i}};

  always_comb begin
    sel_o = '0;
    if (valid_o) sel_o[win_idx] = 1'b1;
  end

  always_comb begin
    lock_d = 1'b0;
    lidx_d = lidx_q;
    if (valid_o && !data_gnt_i) begin
      lock_d = 1'b1;
      lidx_d = win_idx;
    end
  end

`ifdef AXI_RR_QUOTA_EN
  localparam int CNT_W = $clog2(QUOTA) + 1;

  logic [WIDTH-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;

  // Pointer stays on the winner until it has used up its quota of consecutive handshakes
  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    cnt_n   = '0;
    if (hs) begin
      cnt_n   = (win_idx == owner_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
      owner_d = win_idx;
      if (cnt_n == CNT_W'(QUOTA)) begin
        ptr_d = next_idx(win_idx);
        cnt_d = '0;
      end else begin
        ptr_d = win_idx;
        cnt_d = cnt_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = next_idx(win_idx);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
      lidx_q <= lidx_d;
    end
  end

endmodule

// File: tb/tb_axi_rr_flag_arbiter.sv
// Bench for axi_rr_flag_arbiter: distance-based arbitration model checked every cycle,
// plus directed vectors with literal expectations (8-way and 5-way instances).
module tb_axi_rr_flag_arbiter;

  localparam int N     = 8;
  localparam int QUOTA = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       gnt = 1'b0;
  logic       valid_w;
  logic [7:0] sel_w;
  logic [7:0] gnt_w;
  logic [2:0] idx_w;
  logic [2:0] rr_w;
  logic       lock_w;

  logic [4:0] req5 = 5'h00;
  logic       gnt5 = 1'b0;
  logic       valid5;
  logic [4:0] sel5;
  logic [4:0] gnt5_w;
  logic [2:0] idx5;
  logic [2:0] rr5;
  logic       lock5;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: pointer, lock and quota bookkeeping as plain integers
  int m_ptr   = 0;
  bit m_lock  = 1'b0;
  int m_lidx  = 0;
  int m_owner = 0;
  int m_cnt   = 0;

  axi_rr_flag_arbiter #(.N_REQ(N), .QUOTA(QUOTA)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .data_gnt_i (gnt),
    .valid_o    (valid_w),
    .sel_o      (sel_w),
    .gnt_o      (gnt_w),
    .idx_o      (idx_w),
    .RR_FLAG_o  (rr_w),
    .lock_o     (lock_w)
  );

  axi_rr_flag_arbiter #(.N_REQ(5), .QUOTA(1)) u_dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req5),
    .data_gnt_i (gnt5),
    .valid_o    (valid5),
    .sel_o      (sel5),
    .gnt_o      (gnt5_w),
    .idx_o      (idx5),
    .RR_FLAG_o  (rr5),
    .lock_o     (lock5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Winner = locked requester if still requesting, else the requester at the smallest
  // cyclic distance ahead of the pointer. Returns -1 when nobody requests.
  function automatic int m_winner(input logic [7:0] r);
    int best = -1;
    int bd   = N;
    if (m_lock && r[m_lidx[2:0]]) return m_lidx;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        int d = (i - m_ptr + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_lock = 1'b0; m_lidx = 0; m_owner = 0; m_cnt = 0;
    end else begin
      int w;
      int cn;
      w = m_winner(req);
      if (w >= 0 && gnt) begin
`ifdef AXI_RR_QUOTA_EN
        cn      = (w == m_owner) ? m_cnt + 1 : 1;
        m_owner = w;
        if (cn == QUOTA) begin
          m_ptr = (w + 1) % N;
          m_cnt = 0;
        end else begin
          m_ptr = w;
          m_cnt = cn;
        end
`else
        cn    = 0;
        m_ptr = (w + 1) % N;
`endif
        m_lock = 1'b0;
      end else if (w >= 0) begin
        m_lock = 1'b1;
        m_lidx = w;
      end else begin
        m_lock = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    logic [7:0] esel;
    #3;
    w    = m_winner(req);
    esel = (w >= 0) ? (8'h01 << w) : 8'h00;
    chk("m_valid", {31'd0, valid_w}, {31'd0, |req});
    chk("m_sel", {24'd0, sel_w}, {24'd0, esel});
    chk("m_gnt", {24'd0, gnt_w}, {24'd0, esel & {8{gnt}}});
    if (w >= 0) chk("m_idx", {29'd0, idx_w}, w);
    chk("m_rr", {29'd0, rr_w}, m_ptr);
    chk("m_lock", {31'd0, lock_w}, {31'd0, m_lock});
  end

  task automatic drive(input logic [7:0] r, input logic g);
    @(negedge clk);
    req = r;
    gnt = g;
    #2;
  endtask

  task automatic drive5(input logic [4:0] r, input logic g);
    @(negedge clk);
    req5 = r;
    gnt5 = g;
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("rst_rr", {29'd0, rr_w}, 0);
    chk("rst_lock", {31'd0, lock_w}, 0);
    chk("rst_valid", {31'd0, valid_w}, 0);
    chk("rst_sel", {24'd0, sel_w}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // all requesting, ready every cycle: one grant per cycle rotating 0..7
    for (int k = 0; k < 10; k++) begin
      drive(8'hFF, 1'b1);
      chk("t1_idx", {29'd0, idx_w}, k % 8);
      chk("t1_rr", {29'd0, rr_w}, k % 8);
      chk("t1_gnt", {24'd0, gnt_w}, 32'd1 << (k % 8));
    end

    // stall lock with pointer at 2; requester 3 arrives but 4 stays held
    drive(8'h10, 1'b0);
    chk("t2_rr", {29'd0, rr_w}, 2);
    chk("t2_idx_c1", {29'd0, idx_w}, 4);
    chk("t2_lock_c1", {31'd0, lock_w}, 0);
    drive(8'h18, 1'b0);
    chk("t2_idx_c2", {29'd0, idx_w}, 4);
    chk("t2_lock_c2", {31'd0, lock_w}, 1);
    drive(8'h18, 1'b0);
    chk("t2_idx_c3", {29'd0, idx_w}, 4);
    drive(8'h18, 1'b1);
    chk("t2_gnt", {24'd0, gnt_w}, 32'h10);
    drive(8'h08, 1'b1);
    chk("t2_rr5", {29'd0, rr_w}, 5);
    chk("t2_idx3", {29'd0, idx_w}, 3);
    chk("t2_unlock", {31'd0, lock_w}, 0);

    // protocol violation: locked on 6, request drops while 1 requests
    drive(8'h40, 1'b0);
    chk("t4_idx6", {29'd0, idx_w}, 6);
    drive(8'h42, 1'b0);
    chk("t4_lock", {31'd0, lock_w}, 1);
    chk("t4_held6", {29'd0, idx_w}, 6);
    drive(8'h02, 1'b1);
    chk("t4_idx1", {29'd0, idx_w}, 1);
    chk("t4_gnt1", {24'd0, gnt_w}, 32'h02);
    chk("t4_lock_still", {31'd0, lock_w}, 1);
    drive(8'h00, 1'b0);
    chk("t4_lock_clr", {31'd0, lock_w}, 0);
    chk("t4_rr2", {29'd0, rr_w}, 2);

    // async reset while locked with pointer 5
    drive(8'h10, 1'b1);
    drive(8'h40, 1'b0);
    chk("t5_rr5", {29'd0, rr_w}, 5);
    drive(8'h40, 1'b0);
    chk("t5_lock", {31'd0, lock_w}, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rr0", {29'd0, rr_w}, 0);
    chk("t5_lock0", {31'd0, lock_w}, 0);
    chk("t5_valid", {31'd0, valid_w}, 1);
    chk("t5_idx", {29'd0, idx_w}, 6);
    @(negedge clk);
    rst_n = 1'b1;

    // two requesters, ready every cycle
    for (int k = 0; k < 8; k++) begin
      drive(8'h03, 1'b1);
`ifdef AXI_RR_QUOTA_EN
      chk("t6_idx", {29'd0, idx_w}, (k / 4) % 2);
`else
      chk("t6_idx", {29'd0, idx_w}, k % 2);
`endif
    end
    drive(8'h00, 1'b0);

    // 5-way instance: pointer wraps 4 -> 0, never reaches 5..7
    for (int k = 0; k < 3; k++) begin
      drive5(5'b10000, 1'b1);
      chk("t3_idx4", {29'd0, idx5}, 4);
      chk("t3_rr0", {29'd0, rr5}, 0);
      chk("t3_gnt", {27'd0, gnt5_w}, 32'h10);
    end
    drive5(5'b01000, 1'b1);
    chk("t3_rr_wrap", {29'd0, rr5}, 0);
    chk("t3_idx3", {29'd0, idx5}, 3);
    drive5(5'b10000, 1'b1);
    chk("t3_rr4", {29'd0, rr5}, 4);
    chk("t3_sel", {27'd0, sel5}, 32'h10);
    drive5(5'b00000, 1'b0);
    chk("t3_rr_end", {29'd0, rr5}, 0);
    chk("t3_valid0", {31'd0, valid5}, 0);
    chk("t3_lock0", {31'd0, lock5}, 0);

    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
